// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider (a / b) with start/done handshake.
// Radix-2 restoring mantissa divide, truncating, denormals flushed to zero.
module fp_divider_seq #(
    parameter logic [30:0] NAN_MAG = 31'h7FFFFFFF,
    parameter logic [30:0] INF_MAG = 31'h7F800000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        dz
);

    typedef enum logic [2:0] {IDLE, CHECK, DIV, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [24:0] rem_q, rem_d, quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d, busy_q, busy_d, dz_q, dz_d;

    logic [7:0]        ea, eb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    logic [24:0]       mb_ext, r_next;
    logic              ge;
    logic signed [9:0] exp_s;
    logic [22:0]       frac;

    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        a_nan  = (ea == 8'hFF) && (a_q[22:0] != '0);
        b_nan  = (eb == 8'hFF) && (b_q[22:0] != '0);
        a_inf  = (ea == 8'hFF) && (a_q[22:0] == '0);
        b_inf  = (eb == 8'hFF) && (b_q[22:0] == '0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        sgn    = a_q[31] ^ b_q[31];

        mb_ext = {2'b01, b_q[22:0]};
        ge     = (rem_q >= mb_ext);
        r_next = ge ? (rem_q - mb_ext) : rem_q;

        // Quotient in [0.5, 2): a leading 1 at weight 2^0 bumps the exponent by one.
        exp_s  = $signed({2'b00, ea}) - $signed({2'b00, eb})
                 + (quo_q[24] ? 10'sd127 : 10'sd126);
        frac   = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        dz_d     = dz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                dz_d    = 1'b0;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_d = {1'b0, NAN_MAG};
                end else if (a_inf) begin
                    result_d = {sgn, INF_MAG};
                end else if (b_zero) begin
                    result_d = {sgn, INF_MAG};
                    dz_d     = 1'b1;
                end else if (a_zero || b_inf) begin
                    result_d = {sgn, 31'h0};
                end else begin
                    state_d = DIV;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    rem_d   = {2'b01, a_q[22:0]};
                    quo_d   = '0;
                    cnt_d   = '0;
                end
            end
            DIV: begin
                rem_d = r_next << 1;
                quo_d = {quo_q[23:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24) state_d = NORM;
            end
            NORM: begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                dz_d    = 1'b0;
                if (exp_s >= 10'sd255)    result_d = {sgn, INF_MAG};
                else if (exp_s <= 10'sd0) result_d = {sgn, 31'h0};
                else                      result_d = {sgn, exp_s[7:0], frac};
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            dz_q     <= dz_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign dz     = dz_q;

endmodule
